// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and widths for the frame draw scheduler and its pixel walker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_draw_scheduler_pkg;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;
   // Sprite counters must reach 15 (sprites up to 16 pixels per side).
   localparam int CNT_W    = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ERASE_P = 3'd1,
      ST_ERASE_O = 3'd2,
      ST_DRAW_P  = 3'd3,
      ST_DRAW_O  = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/sprite_pixel_walker.sv
// Walks one sprite rectangle in raster order and presents one pixel per cycle.
// Latency: a pixel appears on the registered outputs 1 cycle after it is walked.
// Backpressure: while plot && !plot_ready, outputs hold and counters freeze; off-screen pixels go out with plot=0.
module sprite_pixel_walker
   import frame_draw_scheduler_pkg::*;
#(
   parameter int SPRITE_W = 4,
   parameter int SPRITE_H = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_run,
   input  logic [X_W-1:0]      i_base_x,
   input  logic [Y_W-1:0]      i_base_y,
   input  logic [COLOUR_W-1:0] i_colour,
   input  logic                i_plot_ready,
   output logic [X_W-1:0]      o_x,
   output logic [Y_W-1:0]      o_y,
   output logic [COLOUR_W-1:0] o_colour,
   output logic                o_plot,
   output logic                o_free,
   output logic                o_last
);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(SPRITE_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(SPRITE_H - 1);

   logic [CNT_W-1:0] r_col;
   logic [CNT_W-1:0] r_row;
   logic [X_W-1:0]   w_px;
   logic [Y_W-1:0]   w_py;
   logic             w_on;
   logic             w_free;
   logic             w_col_end;
   logic             w_row_end;

   // Pixel address (wrapping adds), visibility, and the output-register free condition.
   always_comb begin
      w_px      = i_base_x + X_W'(r_col);
      w_py      = i_base_y + Y_W'(r_row);
      w_on      = (int'(w_px) < SCREEN_W) && (int'(w_py) < SCREEN_H);
      w_free    = !o_plot || i_plot_ready;
      w_col_end = (r_col == COL_LAST);
      w_row_end = (r_row == ROW_LAST);
      o_free    = w_free;
      o_last    = i_run && w_free && w_col_end && w_row_end;
   end

   // Load the next pixel when the output register is free; counters wrap to 0 after the last pixel.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_col    <= '0;
         r_row    <= '0;
         o_x      <= '0;
         o_y      <= '0;
         o_colour <= '0;
         o_plot   <= 1'b0;
      end else if (w_free) begin
         if (i_run) begin
            o_x      <= w_px;
            o_y      <= w_py;
            o_colour <= i_colour;
            o_plot   <= w_on;
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + CNT_W'(1);
            end else begin
               r_col <= r_col + CNT_W'(1);
            end
         end else begin
            o_plot <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame pixel sequencer: erase old player/obstacle, then draw both at newly sampled positions.
// Latency: first plot 2 cycles after the sampled tick; passes run back to back, one pixel per cycle.
// Backpressure: plot_ready low freezes the whole sequence; ticks while busy queue one frame deep.
module frame_draw_scheduler
   import frame_draw_scheduler_pkg::*;
#(
   parameter int                  SPRITE_W        = 4,
   parameter int                  SPRITE_H        = 4,
   parameter int                  SCREEN_W        = 160,
   parameter int                  SCREEN_H        = 120,
   parameter logic [COLOUR_W-1:0] BG_COLOUR       = 3'b000,
   parameter logic [COLOUR_W-1:0] PLAYER_COLOUR   = 3'b100,
   parameter logic [COLOUR_W-1:0] OBSTACLE_COLOUR = 3'b001
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_frame_tick,
   input  logic [X_W-1:0]      i_player_x,
   input  logic [Y_W-1:0]      i_player_y,
   input  logic [X_W-1:0]      i_obstacle_x,
   input  logic [Y_W-1:0]      i_obstacle_y,
   input  logic                i_plot_ready,
   output logic [X_W-1:0]      o_x,
   output logic [Y_W-1:0]      o_y,
   output logic [COLOUR_W-1:0] o_colour,
   output logic                o_plot,
   output logic                o_busy,
   output logic                o_frame_done
);

   state_t             r_state;
   logic               r_pending;
   logic               r_old_valid;
   logic               r_tail;
   logic [X_W-1:0]     r_old_px, r_old_ox, r_new_px, r_new_ox;
   logic [Y_W-1:0]     r_old_py, r_old_oy, r_new_py, r_new_oy;

   state_t             w_next_state;
   logic               w_start;
   logic               w_commit;
   logic               w_run;
   logic [X_W-1:0]     w_base_x;
   logic [Y_W-1:0]     w_base_y;
   logic [COLOUR_W-1:0] w_colour;
   logic               w_free;
   logic               w_last;

   sprite_pixel_walker #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_walker (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_run        (w_run),
      .i_base_x     (w_base_x),
      .i_base_y     (w_base_y),
      .i_colour     (w_colour),
      .i_plot_ready (i_plot_ready),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_colour     (o_colour),
      .o_plot       (o_plot),
      .o_free       (w_free),
      .o_last       (w_last)
   );

   // Walker base and colour per pass; the final pass stops walking once its last pixel is loaded.
   always_comb begin
      w_run    = 1'b0;
      w_base_x = r_new_px;
      w_base_y = r_new_py;
      w_colour = PLAYER_COLOUR;
      case (r_state)
         ST_ERASE_P: begin
            w_run    = 1'b1;
            w_base_x = r_old_px;
            w_base_y = r_old_py;
            w_colour = BG_COLOUR;
         end
         ST_ERASE_O: begin
            w_run    = 1'b1;
            w_base_x = r_old_ox;
            w_base_y = r_old_oy;
            w_colour = BG_COLOUR;
         end
         ST_DRAW_P: begin
            w_run    = 1'b1;
         end
         ST_DRAW_O: begin
            w_run    = !r_tail;
            w_base_x = r_new_ox;
            w_base_y = r_new_oy;
            w_colour = OBSTACLE_COLOUR;
         end
         default: begin
            w_run    = 1'b0;
         end
      endcase
   end

   // Next-state and status decode. Intermediate passes advance as their last pixel is loaded so
   // the next pass overlaps; the frame only finishes once the very last pixel has left the walker.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_commit     = 1'b0;
      o_busy       = (r_state != ST_IDLE);
      o_frame_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_frame_tick || r_pending) begin
               w_start      = 1'b1;
               w_next_state = r_old_valid ? ST_ERASE_P : ST_DRAW_P;
            end
         end
         ST_ERASE_P: if (w_last) w_next_state = ST_ERASE_O;
         ST_ERASE_O: if (w_last) w_next_state = ST_DRAW_P;
         ST_DRAW_P:  if (w_last) w_next_state = ST_DRAW_O;
         ST_DRAW_O:  if (r_tail && w_free) w_next_state = ST_DONE;
         ST_DONE: begin
            o_frame_done = 1'b1;
            w_commit     = 1'b1;
            if (r_pending) begin
               w_start      = 1'b1;
               w_next_state = ST_ERASE_P;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State, one-deep pending tick, position snapshots and the final-pass drain flag.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_pending   <= 1'b0;
         r_old_valid <= 1'b0;
         r_tail      <= 1'b0;
         r_old_px    <= '0;
         r_old_py    <= '0;
         r_old_ox    <= '0;
         r_old_oy    <= '0;
         r_new_px    <= '0;
         r_new_py    <= '0;
         r_new_ox    <= '0;
         r_new_oy    <= '0;
      end else begin
         r_state   <= w_next_state;
         r_pending <= (r_pending && !w_start) || (i_frame_tick && (r_state != ST_IDLE));
         if (w_commit) begin
            r_old_px    <= r_new_px;
            r_old_py    <= r_new_py;
            r_old_ox    <= r_new_ox;
            r_old_oy    <= r_new_oy;
            r_old_valid <= 1'b1;
         end
         if (w_start) begin
            r_new_px <= i_player_x;
            r_new_py <= i_player_y;
            r_new_ox <= i_obstacle_x;
            r_new_oy <= i_obstacle_y;
         end
         if ((r_state == ST_DRAW_O) && w_last) begin
            r_tail <= 1'b1;
         end else if (r_state != ST_DRAW_O) begin
            r_tail <= 1'b0;
         end
      end
   end

endmodule
